instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program counter width in bits.
REQ-002 Parameter MUL_CYCLES, default 4: total execute cycles for a multiply, legal range 2..15.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin fetching from PC while IDLE.
REQ-006 stop  input  1  return to IDLE after the current instruction retires.
REQ-007 mem_data  input  16  instruction word from program memory.
REQ-008 mem_ready  input  1  mem_data valid this cycle.
REQ-009 CWin  input  19  control word from the instruction decoder.
REQ-010 mem_rd  output  1  one-cycle program-memory read strobe.
REQ-011 pc  output  PC_W  address of the next instruction.
REQ-012 ISout  output  14  IR[13:0] driven to the decoder.
REQ-013 CWout  output  19  gated control word to the datapath.
REQ-014 instr_done  output  1  one-cycle pulse per retired instruction.
REQ-015 halted  output  1  high in HALT.
REQ-016 illegal  output  1  sticky; set on an illegal instruction.

Function
REQ-017 The block SHALL be a Moore FSM with states IDLE, FETCH, WAIT_MEM, DECODE, EXECUTE, MUL_WAIT, WRITEBACK and HALT.
REQ-018 In IDLE, start=1 SHALL move the FSM to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-019 FETCH SHALL last exactly one cycle, assert mem_rd=1 with address pc, and go to WAIT_MEM.
REQ-020 WAIT_MEM SHALL hold until mem_ready=1, then load IR<=mem_data, set pc<=pc+1 (wrapping from 2^PC_W-1 to 0), and go to DECODE.
REQ-021 mem_ready SHALL be ignored in every state except WAIT_MEM.
REQ-022 In DECODE (one cycle): IR[15:14]=2'b01 SHALL go to EXECUTE; IR=16'hFFFF SHALL go to HALT; any other value SHALL set illegal=1 and go to HALT.
REQ-023 ISout SHALL equal IR[13:0] in every state.
REQ-024 CWout SHALL be all zeros in IDLE, FETCH, WAIT_MEM, DECODE and HALT.
REQ-025 In EXECUTE and MUL_WAIT, CWout SHALL equal CWin with bit 2 (register write) forced to 0.
REQ-026 In WRITEBACK, CWout SHALL equal CWin unmodified.
REQ-027 EXECUTE SHALL go to MUL_WAIT when CWin[18:13]=6'b110101, otherwise to WRITEBACK.
REQ-028 MUL_WAIT SHALL count down and go to WRITEBACK, so that EXECUTE plus MUL_WAIT totals exactly MUL_CYCLES cycles.
REQ-029 WRITEBACK SHALL last one cycle, pulse instr_done=1, and then go to IDLE if stop=1 in that cycle, otherwise to FETCH.
REQ-030 Instruction latency with zero memory wait SHALL be 5 cycles from FETCH to the end of WRITEBACK for a non-multiply instruction, and 4+MUL_CYCLES cycles for a multiply.
REQ-031 Asserting stop in any state other than WRITEBACK SHALL have no effect, and stop SHALL NOT be latched.
REQ-032 HALT SHALL be left only by reset.
REQ-033 halted SHALL be 1 exactly while the FSM is in HALT.

Reset
REQ-034 When rst=1 at a rising edge, the block SHALL apply the following on that edge: state<=IDLE, pc<=0, IR<=0, MUL_WAIT counter<=0, illegal<=0.
REQ-035 Every output SHALL read 0 in the cycle after reset, including mem_rd, CWout, instr_done and halted.
REQ-036 Reset SHALL take priority over all other inputs, including mid-instruction and during a multiply.

Verification
REQ-037 Add, zero wait: reset, start=1 for one cycle, mem_data=16'h5053, CWin=19'h5292C, mem_ready=1 on the cycle after FETCH.
  - Required: mem_rd pulses once.
  - Required: ISout=14'h1053 from DECODE onward.
  - Required: CWout=19'h52928 in EXECUTE.
  - Required: CWout=19'h5292C in WRITEBACK.
  - Required: instr_done pulses in the 5th cycle after FETCH begins; pc=1.
REQ-038 Multiply, MUL_CYCLES=4: CWin[18:13]=6'b110101.
  - Required: CWout bit 2 is 0 for 4 consecutive cycles, then 1 for one cycle.
  - Required: instr_done arrives 3 cycles later than in the REQ-037 scenario.
REQ-039 Memory stall: mem_ready is held low for 3 cycles.
  - Required: the FSM stays in WAIT_MEM, mem_rd is pulsed only once, pc does not change until mem_ready=1.
REQ-040 PC wrap and stop: preload pc to 8'hFF through repeated fetches, then hold stop=1 throughout.
  - Required: after retirement pc=8'h00 and the FSM is in IDLE.
  - Required: stop asserted during EXECUTE alone does not cause the return to IDLE.
REQ-041 Halt and illegal:
  - Required: mem_data=16'hFFFF gives halted=1, illegal=0, and start is ignored.
  - Required: mem_data=16'h8000 gives halted=1 and illegal=1.
  - Required: rst=1 clears both flags and pc.
REQ-042 Reset during a multiply: rst=1 in the second MUL_WAIT cycle.
  - Required: the next cycle shows IDLE, CWout=0, instr_done=0.
  - Required: no WRITEBACK occurs.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches, decodes and steps each instruction through execute and
// writeback, gating the decoder's control word so registers are only written in writeback.
module instr_sequencer #(
  parameter int unsigned PC_W       = 8,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic [15:0]     mem_data_i,
  input  logic            mem_ready_i,
  input  logic [18:0]     cwin_i,
  output logic            mem_rd_o,
  output logic [PC_W-1:0] pc_o,
  output logic [13:0]     isout_o,
  output logic [18:0]     cwout_o,
  output logic            instr_done_o,
  output logic            halted_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitMem,
    StDecode,
    StExecute,
    StMulWait,
    StWriteback,
    StHalt
  } state_e;

  localparam logic [5:0]  MulOpcode = 6'b110101;
  // Execute takes one cycle, so MUL_WAIT runs MUL_CYCLES-1 cycles: counter MUL_CYCLES-2 .. 0.
  localparam logic [3:0]  MulLoad   = 4'(MUL_CYCLES - 2);
  localparam logic [15:0] HaltWord  = 16'hFFFF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            illegal_q, illegal_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        state_d = StWaitMem;
      end
      StWaitMem: begin
        if (mem_ready_i) begin
          ir_d    = mem_data_i;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (ir_q[15:14] == 2'b01) begin
          state_d = StExecute;
        end else begin
          if (ir_q != HaltWord) begin
            illegal_d = 1'b1;
          end
          state_d = StHalt;
        end
      end
      StExecute: begin
        if (cwin_i[18:13] == MulOpcode) begin
          cnt_d   = MulLoad;
          state_d = StMulWait;
        end else begin
          state_d = StWriteback;
        end
      end
      StMulWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StWriteback;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWriteback: begin
        state_d = stop_i ? StIdle : StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs; the control word passes through combinationally but is gated by state.
  always_comb begin
    mem_rd_o     = 1'b0;
    cwout_o      = '0;
    instr_done_o = 1'b0;
    halted_o     = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_rd_o = 1'b1;
      end
      StExecute, StMulWait: begin
        cwout_o = {cwin_i[18:3], 1'b0, cwin_i[1:0]};
      end
      StWriteback: begin
        cwout_o      = cwin_i;
        instr_done_o = 1'b1;
      end
      StHalt: begin
        halted_o = 1'b1;
      end
      default: begin
        mem_rd_o = 1'b0;
      end
    endcase
  end

  assign pc_o      = pc_q;
  assign isout_o   = ir_q[13:0];
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: builds a per-cycle expected trace for each instruction from the
// instruction-level rules, plays it with randomised don't-care inputs and compares outputs.
module tb_instr_sequencer;

  localparam int unsigned PC_W       = 8;
  localparam int unsigned MUL_CYCLES = 4;

  logic            clk;
  logic            rst;
  logic            start;
  logic            stop;
  logic [15:0]     mem_data;
  logic            mem_ready;
  logic [18:0]     cwin;
  logic            mem_rd;
  logic [PC_W-1:0] pc;
  logic [13:0]     isout;
  logic [18:0]     cwout;
  logic            instr_done;
  logic            halted;
  logic            illegal;

  instr_sequencer #(
    .PC_W      (PC_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .mem_data_i  (mem_data),
    .mem_ready_i (mem_ready),
    .cwin_i      (cwin),
    .mem_rd_o    (mem_rd),
    .pc_o        (pc),
    .isout_o     (isout),
    .cwout_o     (cwout),
    .instr_done_o(instr_done),
    .halted_o    (halted),
    .illegal_o   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            rst;
    logic            start;
    logic            stop;
    logic            ready;
    logic [15:0]     data;
    logic [18:0]     cwin;
    logic            rd;
    logic [PC_W-1:0] pc;
    logic [13:0]     is;
    logic [18:0]     cw;
    logic            done;
    logic            halted;
    logic            ill;
  } cyc_t;

  int          n_cmp;
  int          n_bad;
  cyc_t        tq[$];
  int          m_pc;
  logic [15:0] m_ir;
  logic        m_ill;

  int              o_rd_cnt;
  int              o_rd_idx;
  int              o_done_idx;
  int              o_done_cnt;
  logic [PC_W-1:0] o_pc;
  logic            o_halted;
  logic            o_ill;

  // Quiet cycle: random don't-care inputs, nothing strobed, architectural state visible.
  function automatic cyc_t base();
    cyc_t c;
    c.rst    = 1'b0;
    c.start  = 1'($urandom);
    c.stop   = 1'($urandom);
    c.ready  = 1'($urandom);
    c.data   = 16'($urandom);
    c.cwin   = 19'($urandom);
    c.rd     = 1'b0;
    c.pc     = PC_W'(m_pc);
    c.is     = m_ir[13:0];
    c.cw     = '0;
    c.done   = 1'b0;
    c.halted = 1'b0;
    c.ill    = m_ill;
    return c;
  endfunction

  // fill: 0/1 constant, 3 = high only while executing, otherwise random.
  function automatic logic stop_val(input int fill, input bit is_exec);
    case (fill)
      0:       return 1'b0;
      1:       return 1'b1;
      3:       return is_exec;
      default: return 1'($urandom);
    endcase
  endfunction

  function automatic void model_reset();
    m_pc  = 0;
    m_ir  = '0;
    m_ill = 1'b0;
  endfunction

  function automatic void push_idle(input bit st);
    cyc_t c;
    c       = base();
    c.start = st;
    tq.push_back(c);
  endfunction

  function automatic void push_reset();
    cyc_t c;
    c       = base();
    c.start = 1'b1;
    c.rst   = 1'b1;
    tq.push_back(c);
    model_reset();
  endfunction

  function automatic void push_halt(input int n, input bit rst_last);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c        = base();
      c.start  = 1'b1;
      c.halted = 1'b1;
      c.rst    = rst_last && (i == n - 1);
      tq.push_back(c);
    end
    if (rst_last) model_reset();
  endfunction

  // One instruction starting from its fetch cycle; rst_at indexes the execute-phase cycle
  // (0 = EXECUTE) where reset is asserted, -1 for none.
  function automatic void push_instr(input logic [15:0] word, input int w, input bit mul,
                                     input bit use_cw, input logic [18:0] cw_val,
                                     input bit stop_wb, input int fill, input int rst_at);
    cyc_t c;
    int   n;
    c      = base();
    c.rd   = 1'b1;
    c.stop = stop_val(fill, 1'b0);
    tq.push_back(c);
    for (int i = 0; i < w; i++) begin
      c       = base();
      c.ready = 1'b0;
      c.stop  = stop_val(fill, 1'b0);
      tq.push_back(c);
    end
    c       = base();
    c.ready = 1'b1;
    c.data  = word;
    c.stop  = stop_val(fill, 1'b0);
    tq.push_back(c);
    m_pc = (m_pc + 1) % (1 << PC_W);
    m_ir = word;
    c      = base();
    c.stop = stop_val(fill, 1'b0);
    tq.push_back(c);
    if (word[15:14] != 2'b01) begin
      if (word != 16'hFFFF) m_ill = 1'b1;
      return;
    end
    n = mul ? MUL_CYCLES : 1;
    for (int i = 0; i < n; i++) begin
      c = base();
      if (use_cw) c.cwin = cw_val;
      if (i == 0 && !use_cw) begin
        if (mul) c.cwin[18:13] = 6'b110101;
        else while (c.cwin[18:13] == 6'b110101) c.cwin[18:13] = 6'($urandom);
      end
      c.cw   = c.cwin & ~19'h4;
      c.stop = stop_val(fill, 1'b1);
      c.rst  = (i == rst_at);
      tq.push_back(c);
      if (c.rst) begin
        model_reset();
        return;
      end
    end
    c = base();
    if (use_cw) c.cwin = cw_val;
    c.cw   = c.cwin;
    c.done = 1'b1;
    c.stop = stop_wb;
    tq.push_back(c);
  endfunction

  // Drives the queued trace one cycle at a time, comparing outputs at the falling edge.
  task automatic play(input string tag);
    cyc_t        c;
    logic [44:0] act;
    logic [44:0] exp;
    int          idx;
    idx        = 0;
    o_rd_cnt   = 0;
    o_rd_idx   = -1;
    o_done_idx = -1;
    o_done_cnt = 0;
    while (tq.size() > 0) begin
      c         = tq.pop_front();
      rst       = c.rst;
      start     = c.start;
      stop      = c.stop;
      mem_ready = c.ready;
      mem_data  = c.data;
      cwin      = c.cwin;
      @(negedge clk);
      act = {mem_rd, pc, isout, cwout, instr_done, halted, illegal};
      exp = {c.rd, c.pc, c.is, c.cw, c.done, c.halted, c.ill};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got rd=%b pc=%h is=%h cw=%h done=%b halted=%b ill=%b; want rd=%b pc=%h is=%h cw=%h done=%b halted=%b ill=%b",
                 tag, idx, mem_rd, pc, isout, cwout, instr_done, halted, illegal,
                 c.rd, c.pc, c.is, c.cw, c.done, c.halted, c.ill);
      end
      if (mem_rd === 1'b1) begin
        o_rd_cnt++;
        if (o_rd_idx < 0) o_rd_idx = idx;
      end
      if (instr_done === 1'b1) begin
        o_done_cnt++;
        if (o_done_idx < 0) o_done_idx = idx;
      end
      o_pc     = pc;
      o_halted = halted;
      o_ill    = illegal;
      @(posedge clk);
      #1;
      idx++;
    end
    rst       = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b1;
    stop      = 1'b1;
    mem_ready = 1'b1;
    mem_data  = 16'($urandom);
    cwin      = 19'($urandom);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    push_idle(1'b0);
    push_idle(1'b0);
    play("reset");
    n_cmp++;
    if (o_pc !== '0) begin
      n_bad++;
      $display("FAIL reset_pc: got %h want 0", o_pc);
    end
  endtask

  task automatic test_add();
    push_idle(1'b1);
    push_instr(16'h5053, 0, 1'b0, 1'b1, 19'h5292C, 1'b1, 0, -1);
    push_idle(1'b0);
    play("add");
    n_cmp++;
    if (o_rd_cnt !== 1) begin
      n_bad++;
      $display("FAIL add_rd_count: got %0d want 1", o_rd_cnt);
    end
    n_cmp++;
    if (o_done_idx - o_rd_idx + 1 !== 5) begin
      n_bad++;
      $display("FAIL add_latency: got %0d want 5", o_done_idx - o_rd_idx + 1);
    end
    n_cmp++;
    if (o_pc !== 8'h01) begin
      n_bad++;
      $display("FAIL add_pc: got %h want 01", o_pc);
    end
  endtask

  task automatic test_mul();
    push_idle(1'b1);
    push_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 0, 1'b1, 1'b1, 19'h6A004, 1'b1, 0,
               -1);
    push_idle(1'b0);
    play("mul");
    n_cmp++;
    if (o_done_idx - o_rd_idx + 1 !== 4 + MUL_CYCLES) begin
      n_bad++;
      $display("FAIL mul_latency: got %0d want %0d", o_done_idx - o_rd_idx + 1, 4 + MUL_CYCLES);
    end
  endtask

  task automatic test_stall();
    push_idle(1'b1);
    push_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 3, 1'b0, 1'b0, '0, 1'b1, 2, -1);
    push_idle(1'b0);
    play("stall");
    n_cmp++;
    if (o_rd_cnt !== 1) begin
      n_bad++;
      $display("FAIL stall_rd_count: got %0d want 1", o_rd_cnt);
    end
    n_cmp++;
    if (o_done_idx - o_rd_idx + 1 !== 8) begin
      n_bad++;
      $display("FAIL stall_latency: got %0d want 8", o_done_idx - o_rd_idx + 1);
    end
  endtask

  task automatic test_random();
    bit sw;
    push_idle(1'b1);
    for (int k = 0; k < 40; k++) begin
      sw = (k == 39) || ($urandom_range(0, 3) == 0);
      push_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), $urandom_range(0, 3),
                 1'($urandom), 1'b0, '0, sw, 2, -1);
      if (sw && k != 39) begin
        for (int j = 0; j < $urandom_range(0, 2); j++) push_idle(1'b0);
        push_idle(1'b1);
      end
    end
    push_idle(1'b0);
    play("random");
    n_cmp++;
    if (o_done_cnt !== 40) begin
      n_bad++;
      $display("FAIL random_retired: got %0d want 40", o_done_cnt);
    end
  endtask

  task automatic test_pc_wrap();
    push_reset();
    push_idle(1'b1);
    for (int k = 0; k < 255; k++) begin
      push_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 0, 1'b0, 1'b0, '0, 1'b0,
                 (k == 0) ? 3 : 2, -1);
    end
    push_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 0, 1'b0, 1'b0, '0, 1'b1, 1, -1);
    push_idle(1'b0);
    push_idle(1'b0);
    play("pc_wrap");
    n_cmp++;
    if (o_pc !== 8'h00) begin
      n_bad++;
      $display("FAIL wrap_pc: got %h want 00", o_pc);
    end
    n_cmp++;
    if (o_done_cnt !== 256) begin
      n_bad++;
      $display("FAIL wrap_retired: got %0d want 256", o_done_cnt);
    end
  endtask

  task automatic test_halt();
    push_idle(1'b1);
    push_instr(16'hFFFF, $urandom_range(0, 2), 1'b0, 1'b0, '0, 1'b0, 2, -1);
    push_halt(4, 1'b0);
    play("halt");
    n_cmp++;
    if ({o_halted, o_ill} !== 2'b10) begin
      n_bad++;
      $display("FAIL halt_flags: got halted=%b ill=%b want halted=1 ill=0", o_halted, o_ill);
    end
    push_halt(2, 1'b1);
    push_idle(1'b0);
    play("halt_reset");
    n_cmp++;
    if ({o_halted, o_ill, o_pc} !== 10'h000) begin
      n_bad++;
      $display("FAIL halt_clear: got halted=%b ill=%b pc=%h want 0", o_halted, o_ill, o_pc);
    end
    push_idle(1'b1);
    push_instr(16'h8000, 0, 1'b0, 1'b0, '0, 1'b0, 2, -1);
    push_halt(3, 1'b0);
    play("illegal");
    n_cmp++;
    if ({o_halted, o_ill} !== 2'b11) begin
      n_bad++;
      $display("FAIL illegal_flags: got halted=%b ill=%b want halted=1 ill=1", o_halted, o_ill);
    end
    push_halt(1, 1'b1);
    push_idle(1'b0);
    play("illegal_reset");
    n_cmp++;
    if ({o_halted, o_ill, o_pc} !== 10'h000) begin
      n_bad++;
      $display("FAIL illegal_clear: got halted=%b ill=%b pc=%h want 0", o_halted, o_ill, o_pc);
    end
  endtask

  task automatic test_reset_mul();
    push_idle(1'b1);
    push_instr(16'h4000 | 16'($urandom_range(0, 16'h3FFF)), 0, 1'b1, 1'b0, '0, 1'b0, 2, 2);
    push_idle(1'b0);
    push_idle(1'b0);
    play("reset_mul");
    n_cmp++;
    if (o_done_cnt !== 0) begin
      n_bad++;
      $display("FAIL reset_mul_done: got %0d want 0", o_done_cnt);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    mem_ready = 1'b0;
    mem_data  = '0;
    cwin      = '0;
    model_reset();
    test_reset();
    test_add();
    test_mul();
    test_stall();
    test_random();
    test_pc_wrap();
    test_halt();
    test_reset_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
